// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the two-requester memory scheduler.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_DONE
  } state_t;

  localparam int ICACHE   = 0;
  localparam int DCACHE   = 1;
  localparam int READ_BIT = 12;
  localparam int RD_BEATS = 8;
  localparam int WR_BEATS = 9;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arbiter2
  import mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  assign valid = |req;

  always_comb begin
    if (&req) grant = ~last_grant;
    else      grant = req[DCACHE];
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              last_grant <= 1'(DCACHE);
    else if (advance && valid) last_grant <= grant;
  end

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates icache/dcache read and write bursts onto a single Sysbus port.
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             c_reqcyc,
  input  logic [2*WIDTH-1:0]     c_req,
  input  logic [2*TAG_WIDTH-1:0] c_reqtag,
  output logic [1:0]             c_reqack,
  output logic [1:0]             c_respcyc,
  output logic [WIDTH-1:0]       c_resp,
  output logic [TAG_WIDTH-1:0]   c_resptag,
  output logic [1:0]             c_writeack,
  output logic                   bus_reqcyc,
  output logic [WIDTH-1:0]       bus_req,
  output logic [TAG_WIDTH-1:0]   bus_reqtag,
  input  logic                   bus_reqack,
  input  logic                   bus_respcyc,
  input  logic [WIDTH-1:0]       bus_resp,
  input  logic [TAG_WIDTH-1:0]   bus_resptag,
  output logic                   bus_respack
);

  localparam logic [3:0] RD_LAST = 4'(RD_BEATS - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_BEATS - 1);

  state_t               state, next_state;
  logic                 owner;
  logic [3:0]           cnt;
  logic                 beat_valid;
  logic                 grant_idx, grant_valid;
  logic                 handshake, rsp_fire;
  logic [WIDTH-1:0]     req_of [2];
  logic [TAG_WIDTH-1:0] tag_of [2];

  assign req_of[ICACHE] = c_req[WIDTH-1:0];
  assign req_of[DCACHE] = c_req[2*WIDTH-1:WIDTH];
  assign tag_of[ICACHE] = c_reqtag[TAG_WIDTH-1:0];
  assign tag_of[DCACHE] = c_reqtag[2*TAG_WIDTH-1:TAG_WIDTH];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (c_reqcyc),
    .advance (state == IDLE),
    .grant   (grant_idx),
    .valid   (grant_valid)
  );

  // A write beat is withheld from the bus while its requester has paused.
  assign bus_reqcyc  = beat_valid && (state != WR_DATA || c_reqcyc[owner]);
  assign handshake   = bus_reqcyc && bus_reqack;
  assign rsp_fire    = (state == RD_DATA) && bus_respcyc;
  assign bus_respack = rsp_fire;
  assign c_writeack  = (state == WR_DONE) ? onehot2(owner) : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_valid) next_state = tag_of[grant_idx][READ_BIT] ? RD_REQ : WR_DATA;
      RD_REQ:  if (handshake) next_state = RD_DATA;
      RD_DATA: if (bus_respcyc && cnt == RD_LAST) next_state = IDLE;
      WR_DATA: if (handshake && cnt == WR_LAST) next_state = WR_DONE;
      WR_DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      cnt        <= '0;
      beat_valid <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
      c_reqack   <= '0;
      c_respcyc  <= '0;
      c_resp     <= '1;
      c_resptag  <= '0;
    end else begin
      c_reqack <= '0;
      if (rsp_fire) begin
        c_respcyc <= onehot2(owner);
        c_resp    <= bus_resp;
        c_resptag <= bus_resptag;
      end else begin
        c_respcyc <= '0;
        c_resp    <= '1;
      end
      unique case (state)
        IDLE: if (grant_valid) begin
          owner      <= grant_idx;
          bus_req    <= req_of[grant_idx];
          bus_reqtag <= tag_of[grant_idx];
          beat_valid <= 1'b1;
          cnt        <= '0;
        end
        RD_REQ: if (handshake) begin
          beat_valid <= 1'b0;
          c_reqack   <= onehot2(owner);
        end
        RD_DATA: if (bus_respcyc) cnt <= cnt + 4'd1;
        WR_DATA: begin
          if (handshake) begin
            beat_valid <= 1'b0;
            c_reqack   <= onehot2(owner);
            cnt        <= cnt + 4'd1;
          // The requester only presents its next beat after seeing c_reqack.
          end else if (!beat_valid && c_reqack == 2'b00 && c_reqcyc[owner]) begin
            bus_req    <= req_of[owner];
            bus_reqtag <= tag_of[owner];
            beat_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
